// File: rtl/master_port_if.sv
// Host command/response handshake plus the serial arbiter-side bus of one master port.
// The master modport is the port's own view; slave is the host/arbiter view.
interface master_port_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [1:0]        cmd_slave;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              m_request;
    logic              m_address_valid;
    logic              m_address;
    logic              m_data;
    logic              m_valid;
    logic              m_write_en;
    logic              m_available;
    logic              m_ready;
    logic              m_data_in;
    logic              m_valid_in;
    logic              busy;

    modport master (
        input  cmd_valid, cmd_write, cmd_slave, cmd_addr, cmd_wdata, rsp_ready,
               m_available, m_ready, m_data_in, m_valid_in,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, m_request, m_address_valid,
               m_address, m_data, m_valid, m_write_en, busy
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_slave, cmd_addr, cmd_wdata, rsp_ready,
               m_available, m_ready, m_data_in, m_valid_in,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, m_request, m_address_valid,
               m_address, m_data, m_valid, m_write_en, busy
    );
endinterface

// File: rtl/master_port.sv
// Serial bus master port: takes one host command, arbitrates, selects a slave,
// shifts address and data MSB first, and returns a single response.
module master_port #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    master_port_if.master   bus
);
    typedef enum logic [3:0] {
        IDLE, REQ, SEL1, SEL0, CONNECT, WAIT_RDY, ADDR, WDATA, RDATA, DONE
    } state_t;

    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(TIMEOUT);

    state_t            state_q, state_d;
    logic              abort;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              write_q, write_d;
    logic [1:0]        slave_q, slave_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic cmd_ready, rsp_valid, m_request, m_address_valid;
    logic m_address, m_data, m_valid, m_write_en;

    // NOTE: non-blocking assignments make every flop sample pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every signal gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        unique case (state_q)
            IDLE: if (bus.cmd_valid) begin
                if (bus.cmd_slave == 2'b11) begin
                    state_d = DONE;
                    abort   = 1'b1;
                end else begin
                    state_d = REQ;
                end
            end
            REQ:      if (bus.m_available) state_d = SEL1;
            SEL1:     state_d = SEL0;
            SEL0:     state_d = CONNECT;
            CONNECT:  state_d = WAIT_RDY;
            WAIT_RDY: if (bus.m_ready) begin
                state_d = ADDR;
            end else if (to_cnt_q == TO_LAST) begin
                state_d = DONE;
                abort   = 1'b1;
            end
            ADDR:     if (bit_cnt_q == ADDR_LAST) state_d = write_q ? WDATA : RDATA;
            WDATA:    if (bit_cnt_q == DATA_LAST) state_d = DONE;
            RDATA:    if (bus.m_valid_in) begin
                if (bit_cnt_q == DATA_LAST) state_d = DONE;
            end else if (to_cnt_q == TO_LAST) begin
                state_d = DONE;
                abort   = 1'b1;
            end
            DONE:     if (bus.rsp_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready       = 1'b0;
        rsp_valid       = 1'b0;
        m_request       = 1'b0;
        m_address_valid = 1'b0;
        m_address       = 1'b0;
        m_data          = 1'b0;
        m_valid         = 1'b0;
        m_write_en      = 1'b0;
        unique case (state_q)
            IDLE:     cmd_ready = 1'b1;
            REQ: begin
                m_request       = 1'b1;
                m_address_valid = 1'b1;
            end
            SEL1: begin
                m_request = 1'b1;
                m_address = slave_q[1];
            end
            SEL0: begin
                m_request = 1'b1;
                m_address = slave_q[0];
            end
            CONNECT, WAIT_RDY, RDATA: m_request = 1'b1;
            ADDR: begin
                m_request  = 1'b1;
                m_valid    = 1'b1;
                m_write_en = write_q;
                m_address  = addr_q[ADDR_W-1];
            end
            WDATA: begin
                m_request  = 1'b1;
                m_valid    = 1'b1;
                m_write_en = 1'b1;
                m_data     = wdata_q[DATA_W-1];
            end
            DONE:     rsp_valid = 1'b1;
            default:  cmd_ready = 1'b0;
        endcase
    end

    // Address and write data are consumed by left-shifting their latches.
    always_comb begin
        write_d   = write_q;
        slave_d   = slave_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        bit_cnt_d = bit_cnt_q;
        to_cnt_d  = to_cnt_q;

        if (state_q == IDLE && bus.cmd_valid) begin
            write_d = bus.cmd_write;
            slave_d = bus.cmd_slave;
            addr_d  = bus.cmd_addr;
            wdata_d = bus.cmd_wdata;
            rdata_d = '0;
            err_d   = 1'b0;
        end
        if (abort) err_d = 1'b1;
        if (state_q == ADDR)  addr_d  = {addr_q[ADDR_W-2:0], 1'b0};
        if (state_q == WDATA) wdata_d = {wdata_q[DATA_W-2:0], 1'b0};
        if (state_q == RDATA && bus.m_valid_in) rdata_d = {rdata_q[DATA_W-2:0], bus.m_data_in};

        if (state_d != state_q) begin
            bit_cnt_d = '0;
            to_cnt_d  = '0;
        end else begin
            if (state_q == ADDR || state_q == WDATA || (state_q == RDATA && bus.m_valid_in))
                bit_cnt_d = bit_cnt_q + 1'b1;
            if ((state_q == WAIT_RDY && bus.m_ready) || (state_q == RDATA && bus.m_valid_in))
                to_cnt_d = '0;
            else if ((state_q == WAIT_RDY || state_q == RDATA) && to_cnt_q != TO_MAX)
                to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_q   <= 1'b0;
            slave_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            write_q   <= write_d;
            slave_q   <= slave_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            bit_cnt_q <= bit_cnt_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    assign bus.cmd_ready       = cmd_ready;
    assign bus.rsp_valid       = rsp_valid;
    assign bus.rsp_rdata       = rdata_q;
    assign bus.rsp_err         = err_q;
    assign bus.m_request       = m_request;
    assign bus.m_address_valid = m_address_valid;
    assign bus.m_address       = m_address;
    assign bus.m_data          = m_data;
    assign bus.m_valid         = m_valid;
    assign bus.m_write_en      = m_write_en;
    assign bus.busy            = (state_q != IDLE);
endmodule

// File: tb/tb_master_port.sv
// Directed and randomized transactions for master_port; expected bus activity and
// responses come from a cycle-level reading of the port's transfer rules.
module tb_master_port;
    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    master_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    master_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
        check({tag, "_rsp_err"},   bus.rsp_err, 0);
        check({tag, "_busy"},      bus.busy, 0);
        check({tag, "_m_bus"}, {bus.m_request, bus.m_address_valid, bus.m_address,
                                bus.m_data, bus.m_valid, bus.m_write_en}, 0);
    endtask

    // One complete command. rdy_dly >= TIMEOUT means m_ready never comes;
    // rd_bits < DATA_W means m_valid_in stalls for good after that many bits.
    task automatic run_cmd(input logic wr, input logic [1:0] sl, input logic [ADDR_W-1:0] ad,
                           input logic [DATA_W-1:0] wd, input int avail_dly, input int rdy_dly,
                           input logic [DATA_W-1:0] rd_val, input int rd_bits, input int max_gap);
        logic              exp_err;
        logic [DATA_W-1:0] exp_rdata;
        int                hold;
        exp_err   = 1'b0;
        exp_rdata = '0;

        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_slave = sl;
        bus.cmd_addr  = ad;
        bus.cmd_wdata = wd;
        check("idle_cmd_ready", bus.cmd_ready, 1);
        check("idle_busy", bus.busy, 0);
        step();
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;

        if (sl == 2'b11) begin
            exp_err = 1'b1;
        end else begin
            for (int i = 0; i <= avail_dly; i++) begin
                bus.m_available = (i == avail_dly);
                check("req_m_request", bus.m_request, 1);
                check("req_addr_valid", bus.m_address_valid, 1);
                check("req_busy", bus.busy, 1);
                step();
            end
            bus.m_available = 1'b0;
            check("sel1_m_address", bus.m_address, sl[1]);
            check("sel1_addr_valid", bus.m_address_valid, 0);
            check("sel1_m_request", bus.m_request, 1);
            step();
            check("sel0_m_address", bus.m_address, sl[0]);
            check("sel0_addr_valid", bus.m_address_valid, 0);
            step();
            check("connect_m_address", bus.m_address, 0);
            check("connect_m_request", bus.m_request, 1);
            step();
            if (rdy_dly >= TIMEOUT) begin
                for (int i = 0; i < TIMEOUT; i++) begin
                    bus.m_ready = 1'b0;
                    check("wait_m_request", bus.m_request, 1);
                    check("wait_m_valid", bus.m_valid, 0);
                    step();
                end
                exp_err = 1'b1;
            end else begin
                for (int i = 0; i <= rdy_dly; i++) begin
                    bus.m_ready = (i == rdy_dly);
                    check("wait_m_request", bus.m_request, 1);
                    check("wait_m_valid", bus.m_valid, 0);
                    step();
                end
                bus.m_ready = 1'b0;
                for (int k = 0; k < ADDR_W; k++) begin
                    check("addr_m_valid", bus.m_valid, 1);
                    check("addr_m_write_en", bus.m_write_en, wr);
                    check("addr_bit", bus.m_address, ad[ADDR_W-1-k]);
                    step();
                end
                if (wr) begin
                    for (int k = 0; k < DATA_W; k++) begin
                        check("wdata_m_valid", bus.m_valid, 1);
                        check("wdata_m_write_en", bus.m_write_en, 1);
                        check("wdata_bit", bus.m_data, wd[DATA_W-1-k]);
                        step();
                    end
                end else begin
                    for (int j = 0; j < rd_bits; j++) begin
                        int gap;
                        gap = $urandom_range(max_gap, 0);
                        for (int g = 0; g < gap; g++) begin
                            bus.m_valid_in = 1'b0;
                            bus.m_data_in  = 1'($urandom);
                            check("rdata_m_request", bus.m_request, 1);
                            check("rdata_m_valid", bus.m_valid, 0);
                            step();
                        end
                        bus.m_valid_in = 1'b1;
                        bus.m_data_in  = rd_val[DATA_W-1-j];
                        check("rdata_m_write_en", bus.m_write_en, 0);
                        step();
                    end
                    bus.m_valid_in = 1'b0;
                    bus.m_data_in  = 1'b0;
                    // First rd_bits bits received, first bit as the most significant.
                    exp_rdata = rd_val >> (DATA_W - rd_bits);
                    if (rd_bits < DATA_W) begin
                        for (int i = 0; i < TIMEOUT; i++) begin
                            check("stall_m_request", bus.m_request, 1);
                            step();
                        end
                        exp_err = 1'b1;
                    end
                end
            end
        end

        check("done_rsp_valid", bus.rsp_valid, 1);
        check("done_rsp_err", bus.rsp_err, exp_err);
        check("done_rsp_rdata", bus.rsp_rdata, exp_rdata);
        check("done_m_request", bus.m_request, 0);
        check("done_busy", bus.busy, 1);
        check("done_cmd_ready", bus.cmd_ready, 0);
        hold = $urandom_range(3, 0);
        for (int i = 0; i < hold; i++) begin
            bus.rsp_ready = 1'b0;
            step();
            check("hold_rsp_valid", bus.rsp_valid, 1);
            check("hold_rsp_rdata", bus.rsp_rdata, exp_rdata);
            check("hold_rsp_err", bus.rsp_err, exp_err);
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("ret_rsp_valid", bus.rsp_valid, 0);
        check("ret_busy", bus.busy, 0);
        check("ret_cmd_ready", bus.cmd_ready, 1);
    endtask

    initial begin
        logic [ADDR_W-1:0] r_addr;
        clk             = 1'b0;
        reset           = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_write   = 1'b0;
        bus.cmd_slave   = 2'b00;
        bus.cmd_addr    = '0;
        bus.cmd_wdata   = '0;
        bus.rsp_ready   = 1'b0;
        bus.m_available = 1'b0;
        bus.m_ready     = 1'b0;
        bus.m_data_in   = 1'b0;
        bus.m_valid_in  = 1'b0;
        #2;
        check_reset_outputs("por");
        step();
        reset = 1'b0;
        step();
        check_reset_outputs("post_reset");

        // Write to slave2 with the arbiter and slave immediately ready.
        run_cmd(1'b1, 2'b01, 12'hA5C, 8'h3C, 0, 0, 8'h00, DATA_W, 0);
        // Read from slave3 returning 1,0,0,1,0,1,1,0 with random gaps.
        run_cmd(1'b0, 2'b10, 12'h123, 8'h00, 0, 2, 8'h96, DATA_W, 3);
        // Illegal slave: immediate error response, no bus activity.
        run_cmd(1'b1, 2'b11, 12'hFFF, 8'hFF, 0, 0, 8'h00, DATA_W, 0);
        // Arbiter grants only after 50 cycles.
        run_cmd(1'b1, 2'b00, 12'h0F0, 8'hA5, 50, 1, 8'h00, DATA_W, 0);
        // m_ready never rises: timeout error.
        run_cmd(1'b1, 2'b01, 12'h555, 8'h5A, 1, TIMEOUT, 8'h00, DATA_W, 0);
        // Read stalls after three bits: timeout error with partial data.
        run_cmd(1'b0, 2'b00, 12'hABC, 8'h00, 0, 0, 8'hB7, 3, 2);

        // Reset during address bit 5 aborts the transfer.
        r_addr          = 12'h7E1;
        bus.m_available = 1'b1;
        bus.m_ready     = 1'b1;
        bus.cmd_valid   = 1'b1;
        bus.cmd_write   = 1'b1;
        bus.cmd_slave   = 2'b10;
        bus.cmd_addr    = r_addr;
        bus.cmd_wdata   = 8'hC3;
        step();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("pre_abort_m_valid", bus.m_valid, 1);
        check("pre_abort_addr_bit5", bus.m_address, r_addr[ADDR_W-1-5]);
        reset = 1'b1;
        #1;
        check_reset_outputs("async_abort");
        bus.m_available = 1'b0;
        bus.m_ready     = 1'b0;
        step();
        check_reset_outputs("held_reset");
        reset = 1'b0;
        step();
        run_cmd(1'b1, 2'b10, 12'h7E1, 8'hC3, 0, 0, 8'h00, DATA_W, 0);

        // Randomized commands.
        for (int t = 0; t < 24; t++) begin
            logic [1:0] sl;
            int rdy, nb;
            sl  = 2'($urandom_range(3, 0));
            rdy = ($urandom_range(7, 0) == 0) ? TIMEOUT + int'($urandom_range(2, 0))
                                               : int'($urandom_range(5, 0));
            nb  = ($urandom_range(5, 0) == 0) ? int'($urandom_range(DATA_W - 1, 0)) : DATA_W;
            run_cmd(1'($urandom), sl, ADDR_W'($urandom), DATA_W'($urandom),
                    int'($urandom_range(4, 0)), rdy, DATA_W'($urandom), nb, 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/master_port.md
MASTER_PORT -- requirements
Module: master_port

Interface
REQ-001 Parameter ADDR_W, default 12, is the number of intra-slave address bits shifted serially, MSB first.
REQ-002 Parameter DATA_W, default 8, is the number of data bits per transfer, shifted serially, MSB first.
REQ-003 Parameter TIMEOUT, default 16, is the maximum number of cycles waited for m_ready or m_valid_in before aborting.
REQ-004 clk  in  1  single clock; all flops rise-edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 cmd_valid/cmd_ready  in/out  1/1  host command handshake; transfer on the edge where both are high.
REQ-007 cmd_write  in  1  1=write, 0=read.
REQ-008 cmd_slave  in  2  slave select: 00=slave1, 01=slave2, 10=slave3, 11=illegal.
REQ-009 cmd_addr/cmd_wdata  in  ADDR_W/DATA_W  address and write data.
REQ-010 rsp_valid/rsp_ready  out/in  1/1  response handshake.
REQ-011 rsp_rdata/rsp_err  out  DATA_W/1  read data; error flag (illegal slave or timeout).
REQ-012 m_request, m_address_valid, m_address, m_data, m_valid, m_write_en  out  1 each  serial bus-side master signals to the arbiter.
REQ-013 m_available, m_ready, m_data_in, m_valid_in  in  1 each  arbiter/slave return signals.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 States: IDLE, REQ, SEL1, SEL0, CONNECT, WAIT_RDY, ADDR, WDATA, RDATA, DONE.
REQ-016 IDLE: cmd_ready=1, all m_* outputs 0. On the handshake, latch cmd_write, cmd_slave, cmd_addr, cmd_wdata. If cmd_slave=11, go to DONE with rsp_err=1 and no bus activity; otherwise go to REQ.
REQ-017 REQ: m_request=1, m_address_valid=1. Advance to SEL1 on the edge where m_available=1; stay otherwise, with no timeout.
REQ-018 SEL1 drives m_address=cmd_slave[1]; SEL0 drives m_address=cmd_slave[0]; CONNECT drives m_address=0. Each lasts exactly one cycle, and m_address_valid=0 in all three.
REQ-019 m_request=1 in every state from REQ through RDATA; m_request=0 in DONE and IDLE.
REQ-020 WAIT_RDY: go to ADDR when m_ready=1. If m_ready stays 0 for TIMEOUT consecutive cycles, go to DONE with rsp_err=1.
REQ-021 ADDR: m_valid=1, m_write_en=cmd_write, m_address=addr[ADDR_W-1-k] in cycle k. Lasts exactly ADDR_W cycles; then go to WDATA if writing, RDATA if reading.
REQ-022 WDATA: m_valid=1, m_write_en=1, m_data=wdata[DATA_W-1-k] in cycle k. Lasts exactly DATA_W cycles; then DONE with rsp_err=0.
REQ-023 RDATA: m_valid=0, m_write_en=0. On each edge with m_valid_in=1, shift m_data_in into rsp_rdata LSB-ward (first bit received ends as MSB). After DATA_W bits, go to DONE with rsp_err=0. If m_valid_in stays 0 for TIMEOUT consecutive cycles, go to DONE with rsp_err=1 and rsp_rdata as partially shifted.
REQ-024 DONE: rsp_valid=1; rsp_rdata and rsp_err are held stable. Return to IDLE on the edge with rsp_ready=1.
REQ-025 Bit counter is wide enough for max(ADDR_W,DATA_W) and clears on every state entry. Timeout counter is wide enough for TIMEOUT, clears on state entry and on each qualifying m_ready or m_valid_in cycle, and never wraps.
REQ-026 rsp_rdata is 0 for writes and illegal-slave errors. A new command is accepted only in IDLE (no overlap).
REQ-027 Loss of m_available after REQ is ignored; recovery is by the WAIT_RDY timeout only.

Reset
REQ-028 Reset asserted forces state=IDLE, clears all counters and latched command fields, and drives outputs to cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, all m_* outputs 0.
REQ-029 Reset asserted mid-transfer aborts the transfer and produces no response; m_request drops immediately, without waiting for a clock edge.

Verification
REQ-030 Write slave2, addr=0xA5C, wdata=0x3C, m_available=1, m_ready=1: m_address shows 0,1 in SEL1/SEL0; 12 address bits 1010_0101_1100; m_data 0011_1100 with m_write_en=1; then rsp_valid=1, rsp_err=0.
REQ-031 Read slave3, m_valid_in pulsed with data bits 1,0,0,1,0,1,1,0: rsp_rdata=0x96, rsp_err=0, m_request low in DONE.
REQ-032 cmd_slave=11: m_request never rises; rsp_valid=1 with rsp_err=1 on the cycle after acceptance.
REQ-033 m_available=0 for 50 cycles then 1: m_request and m_address_valid held high throughout; SEL1 entered on the edge after m_available rises.
REQ-034 m_ready held 0: after 16 cycles in WAIT_RDY, rsp_err=1 and m_request=0; a read with m_valid_in stalled after 3 bits also ends with rsp_err=1.
REQ-035 Reset asserted during ADDR bit 5: all outputs take reset values asynchronously; the next command completes normally.
